// File: rtl/udp_perf_pkt_gen.sv
// Transmit-side perf traffic generator: emits pkt_num packets of pkt_size bytes on AXI-Stream.
// Optional inter-packet idle gap is built when UDP_PERF_PKT_GAP_EN is defined.
module udp_perf_pkt_gen #(
   parameter int DATA_WIDTH = 512,
   parameter int GAP_CYCLES = 1
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    start,
   input  logic [31:0]             pkt_size,
   input  logic [31:0]             pkt_num,
   output logic                    tx_axis_tvalid,
   input  logic                    tx_axis_tready,
   output logic [DATA_WIDTH-1:0]   tx_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] tx_axis_tkeep,
   output logic                    tx_axis_tlast,
   output logic                    tx_axis_tuser,
   output logic                    send_pkt_enable,
   output logic                    send_done,
   output logic [31:0]             perf_cycle_counter,
   output logic [31:0]             total_beat_counter,
   output logic [31:0]             total_pkt_counter
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(KEEP_W);

   if (GAP_CYCLES < 0 || (DATA_WIDTH % 32) != 0) begin : g_bad_cfg
      $error("udp_perf_pkt_gen: unsupported GAP_CYCLES or DATA_WIDTH");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
`ifdef UDP_PERF_PKT_GAP_EN
      ST_GAP  = 2'd2,
`endif
      ST_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       pkt_num_q;
   logic [31:0]       beats_q;
   logic [OFF_W-1:0]  rem_q;
   logic [31:0]       beat_idx;
   logic [31:0]       pkt_idx;
`ifdef UDP_PERF_PKT_GAP_EN
   logic [31:0]       gap_cnt;
`endif

   logic              start_ok;
   logic              can_start;
   logic              handshake;
   logic              last_beat;
   logic              final_pkt;
   logic              in_send;
   logic [31:0]       beats_d;
   logic [31:0]       lane_word;

   // ceil(pkt_size / KEEP_W) without a wide adder; same result as the 33-bit (size+KEEP_W-1)>>OFF_W.
   assign beats_d   = 32'(pkt_size[31:OFF_W]) + 32'(|pkt_size[OFF_W-1:0]);

   assign start_ok  = start && (pkt_size != 32'd0) && (pkt_num != 32'd0);
   assign can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign handshake = tx_axis_tvalid && tx_axis_tready;
   assign last_beat = (beat_idx == beats_q - 32'd1);
   assign final_pkt = (pkt_idx == pkt_num_q - 32'd1);

`ifdef UDP_PERF_PKT_GAP_EN
   assign in_send   = (state_q == ST_SEND) || (state_q == ST_GAP);
`else
   assign in_send   = (state_q == ST_SEND);
`endif

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (handshake && last_beat) begin
               if (final_pkt) begin
                  state_d = ST_DONE;
               end else begin
`ifdef UDP_PERF_PKT_GAP_EN
                  state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_SEND;
`else
                  state_d = ST_SEND;
`endif
               end
            end
         end
`ifdef UDP_PERF_PKT_GAP_EN
         ST_GAP: begin
            if (gap_cnt == 32'(GAP_CYCLES - 1)) state_d = ST_SEND;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Packet/beat indices and latched configuration
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pkt_num_q <= '0;
         beats_q   <= '0;
         rem_q     <= '0;
         beat_idx  <= '0;
         pkt_idx   <= '0;
      end else if (can_start && start_ok) begin
         pkt_num_q <= pkt_num;
         beats_q   <= beats_d;
         rem_q     <= pkt_size[OFF_W-1:0];
         beat_idx  <= '0;
         pkt_idx   <= '0;
      end else if (handshake) begin
         if (last_beat) begin
            beat_idx <= '0;
            pkt_idx  <= pkt_idx + 32'd1;
         end else begin
            beat_idx <= beat_idx + 32'd1;
         end
      end
   end

`ifdef UDP_PERF_PKT_GAP_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gap_cnt <= '0;
      end else if (state_q == ST_GAP) begin
         gap_cnt <= gap_cnt + 32'd1;
      end else begin
         gap_cnt <= '0;
      end
   end
`endif

   // Saturating performance counters, cleared by an accepted start
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         perf_cycle_counter <= '0;
         total_beat_counter <= '0;
         total_pkt_counter  <= '0;
      end else if (can_start && start_ok) begin
         perf_cycle_counter <= '0;
         total_beat_counter <= '0;
         total_pkt_counter  <= '0;
      end else begin
         if (in_send && perf_cycle_counter != '1)
            perf_cycle_counter <= perf_cycle_counter + 32'd1;
         if (handshake && total_beat_counter != '1)
            total_beat_counter <= total_beat_counter + 32'd1;
         if (handshake && last_beat && total_pkt_counter != '1)
            total_pkt_counter <= total_pkt_counter + 32'd1;
      end
   end

   // Beat payload is a pure function of registered indices, so it holds through stalls.
   assign tx_axis_tvalid  = (state_q == ST_SEND);
   assign tx_axis_tlast   = tx_axis_tvalid && last_beat;
   assign tx_axis_tuser   = 1'b0;
   assign send_pkt_enable = in_send;
   assign send_done       = (state_q == ST_DONE);
   assign lane_word       = {pkt_idx[15:0], beat_idx[15:0]};

   always_comb begin
      tx_axis_tkeep = '0;
      tx_axis_tdata = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         if (tx_axis_tvalid) begin
            if (!tx_axis_tlast || rem_q == '0)
               tx_axis_tkeep[i] = 1'b1;
            else
               tx_axis_tkeep[i] = (i < int'(rem_q));
         end
         if (tx_axis_tkeep[i])
            tx_axis_tdata[8*i +: 8] = lane_word[8*(i%4) +: 8];
      end
   end

endmodule

// File: tb/tb_udp_perf_pkt_gen.sv
// Scoreboard bench for udp_perf_pkt_gen: expected beats queued at start, compared on handshakes.
// Works with or without UDP_PERF_PKT_GAP_EN defined.
module tb_udp_perf_pkt_gen;

   localparam int GAP_P = 2;
`ifdef UDP_PERF_PKT_GAP_EN
   localparam int GAP_EXP = GAP_P;
`else
   localparam int GAP_EXP = 0;
`endif

   typedef struct {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
   } beat_t;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         start;
   logic [31:0]  pkt_size;
   logic [31:0]  pkt_num;
   logic         tx_axis_tvalid;
   logic         tx_axis_tready;
   logic [511:0] tx_axis_tdata;
   logic [63:0]  tx_axis_tkeep;
   logic         tx_axis_tlast;
   logic         tx_axis_tuser;
   logic         send_pkt_enable;
   logic         send_done;
   logic [31:0]  perf_cycle_counter;
   logic [31:0]  total_beat_counter;
   logic [31:0]  total_pkt_counter;

   int    n_checks = 0;
   int    n_errors = 0;
   beat_t sb[$];
   beat_t held;
   bit    stall = 1'b0;

   udp_perf_pkt_gen #(.DATA_WIDTH(512), .GAP_CYCLES(GAP_P)) dut (
      .CLK                (CLK),
      .RST_N              (RST_N),
      .start              (start),
      .pkt_size           (pkt_size),
      .pkt_num            (pkt_num),
      .tx_axis_tvalid     (tx_axis_tvalid),
      .tx_axis_tready     (tx_axis_tready),
      .tx_axis_tdata      (tx_axis_tdata),
      .tx_axis_tkeep      (tx_axis_tkeep),
      .tx_axis_tlast      (tx_axis_tlast),
      .tx_axis_tuser      (tx_axis_tuser),
      .send_pkt_enable    (send_pkt_enable),
      .send_done          (send_done),
      .perf_cycle_counter (perf_cycle_counter),
      .total_beat_counter (total_beat_counter),
      .total_pkt_counter  (total_pkt_counter)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Queue every beat the generator should produce for one run.
   task automatic push_expected(input int size, input int num);
      int    bpp;
      int    r;
      beat_t e;
      logic [31:0] lane;
      bpp = (size + 63) / 64;
      r   = size % 64;
      for (int p = 0; p < num; p++) begin
         for (int b = 0; b < bpp; b++) begin
            e.last = (b == bpp - 1);
            e.keep = '1;
            if (e.last && r != 0) e.keep = (64'd1 << r) - 64'd1;
            lane   = {p[15:0], b[15:0]};
            e.data = '0;
            for (int k = 0; k < 64; k++)
               if (e.keep[k]) e.data[8*k +: 8] = lane[8*(k%4) +: 8];
            sb.push_back(e);
         end
      end
   endtask

   // Cycles spent in SEND/GAP; alternating ready is low on the first valid cycle.
   function automatic int model_cycles(input int bpp, input int num, input bit alt, input int gap);
      int t = 0, cyc = 0, b = 0, p = 0;
      bit rdy;
      while (p < num) begin
         rdy = alt ? (t % 2 == 1) : 1'b1;
         cyc++;
         t++;
         if (rdy) begin
            b++;
            if (b == bpp) begin
               b = 0;
               p++;
               if (p < num) begin
                  cyc += gap;
                  t   += gap;
               end
            end
         end
      end
      return cyc;
   endfunction

   // Monitor: pop on handshake, enforce stability while stalled.
   always @(negedge CLK) begin
      beat_t e;
      if (!RST_N) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("hold_valid", tx_axis_tvalid, 1'b1);
            check("hold_data", tx_axis_tdata, held.data);
            check("hold_keep", tx_axis_tkeep, held.keep);
            check("hold_last", tx_axis_tlast, held.last);
         end
         if (tx_axis_tvalid && tx_axis_tready) begin
            stall = 1'b0;
            if (sb.size() == 0) begin
               check("extra_beat", 1'b1, 1'b0);
            end else begin
               e = sb.pop_front();
               check("beat_data", tx_axis_tdata, e.data);
               check("beat_keep", tx_axis_tkeep, e.keep);
               check("beat_last", tx_axis_tlast, e.last);
            end
         end else if (tx_axis_tvalid) begin
            stall     = 1'b1;
            held.data = tx_axis_tdata;
            held.keep = tx_axis_tkeep;
            held.last = tx_axis_tlast;
         end else begin
            stall = 1'b0;
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tvalid"}, tx_axis_tvalid, 1'b0);
      check({tag, "_tdata"}, tx_axis_tdata, '0);
      check({tag, "_tkeep"}, tx_axis_tkeep, '0);
      check({tag, "_tlast"}, tx_axis_tlast, 1'b0);
      check({tag, "_tuser"}, tx_axis_tuser, 1'b0);
      check({tag, "_enable"}, send_pkt_enable, 1'b0);
      check({tag, "_done"}, send_done, 1'b0);
      check({tag, "_cycles"}, perf_cycle_counter, 32'd0);
      check({tag, "_beats"}, total_beat_counter, 32'd0);
      check({tag, "_pkts"}, total_pkt_counter, 32'd0);
   endtask

   task automatic run(input int size, input int num, input bit alt, input bit poke);
      int bpp;
      int cyc_exp;
      bit done_seen = 1'b0;
      bpp     = (size + 63) / 64;
      cyc_exp = model_cycles(bpp, num, alt, GAP_EXP);
      push_expected(size, num);
      tx_axis_tready = 1'b1;
      @(posedge CLK); #1;
      pkt_size = size;
      pkt_num  = num;
      start    = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      if (alt) tx_axis_tready = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         if (send_done) begin
            done_seen = 1'b1;
            break;
         end
         // A start while sending must be ignored.
         if (poke && n == 1) begin
            start    = 1'b1;
            pkt_size = 32'd64;
            pkt_num  = 32'd7;
         end else begin
            start = 1'b0;
         end
         @(posedge CLK); #1;
         if (alt) tx_axis_tready = ~tx_axis_tready;
      end
      start = 1'b0;
      check("done_seen", done_seen, 1'b1);
      check("sb_empty", sb.size(), 0);
      check("beats", total_beat_counter, 32'(num * bpp));
      check("pkts", total_pkt_counter, 32'(num));
      check("cycles", perf_cycle_counter, 32'(cyc_exp));
      check("done_tvalid", tx_axis_tvalid, 1'b0);
      check("done_enable", send_pkt_enable, 1'b0);
      check("done_tuser", tx_axis_tuser, 1'b0);
      tx_axis_tready = 1'b1;
   endtask

   initial begin
      RST_N          = 1'b0;
      start          = 1'b0;
      pkt_size       = '0;
      pkt_num        = '0;
      tx_axis_tready = 1'b1;
      #22;
      check_idle_outputs("reset");
      @(posedge CLK); #1;
      RST_N = 1'b1;

      // Zero-size and zero-count starts are ignored.
      @(posedge CLK); #1;
      pkt_size = 32'd0; pkt_num = 32'd5; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (2) @(posedge CLK);
      #1 check_idle_outputs("zero_size");
      pkt_size = 32'd64; pkt_num = 32'd0; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (2) @(posedge CLK);
      #1 check_idle_outputs("zero_num");

      run(64, 1, 1'b0, 1'b0);
      run(100, 3, 1'b0, 1'b0);
      run(100, 3, 1'b1, 1'b1);
      run(200, 2, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a two-beat packet.
      push_expected(128, 1);
      @(posedge CLK); #1;
      pkt_size = 32'd128; pkt_num = 32'd1; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      check("mid_beat1_valid", tx_axis_tvalid, 1'b1);
      RST_N = 1'b0;
      #1 check_idle_outputs("mid_reset");
      sb.delete();
      @(posedge CLK); #1;
      RST_N = 1'b1;
      run(64, 1, 1'b0, 1'b0);

      // Inter-packet gap (back-to-back when the gap feature is not built).
      run(64, 2, 1'b0, 1'b0);

      repeat (3) @(posedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
